// File: rtl/sound_pkg.sv
// Shared types and constants for the snake-game sound output stage.
//   env_state_t : envelope FSM states
//   LEVEL_MAX   : full-scale envelope level
//   PWM_W       : PWM counter / duty width
//   sat_add / sat_sub : 8-bit saturating level arithmetic
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        DECAY
    } env_state_t;

    localparam logic [7:0] LEVEL_MAX = 8'd255;
    localparam int unsigned PWM_W = 8;

    // 9-bit sum so the carry tells us to clamp at full scale.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? LEVEL_MAX : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/pwm_modulator.sv
// Single-pin PWM generator.
//   clk, rst        : clock, synchronous active-high reset
//   duty_pending_i  : next duty value; sampled only at the period boundary
//   pwm_o           : registered PWM output, high for duty cycles out of 256
module pwm_modulator
    import sound_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty_pending_i,
    output logic             pwm_o
);

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        cnt_d  = cnt_q + PWM_W'(1);
        duty_d = duty_q;
        // Reload only as the counter wraps so a period never sees two duties.
        if (&cnt_q) begin
            duty_d = duty_pending_i;
        end
        pwm_d = (cnt_d < duty_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/sound_envelope_pwm.sv
// Sound output stage: attack/sustain/decay envelope applied to the sawtooth
// sample, then driven to the speaker as 8-bit PWM.
//   clk, rst       : clock, synchronous active-high reset
//   sample_i       : unsigned sawtooth sample
//   sample_tick_i  : one-cycle strobe, sample_i is new
//   note_start_i   : one-cycle strobe, start or retrigger the envelope
//   pwm_o          : PWM speaker drive
//   level_o        : current envelope level
//   busy_o         : envelope not idle
module sound_envelope_pwm
    import sound_pkg::*;
#(
    parameter int unsigned ENV_DIV       = 120000,
    parameter int unsigned ATTACK_STEP   = 8,
    parameter int unsigned DECAY_STEP    = 2,
    parameter int unsigned SUSTAIN_TICKS = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_i,
    input  logic       sample_tick_i,
    input  logic       note_start_i,
    output logic       pwm_o,
    output logic [7:0] level_o,
    output logic       busy_o
);

    localparam int unsigned PRESC_W = $clog2(ENV_DIV);
    localparam int unsigned HOLD_W  = (SUSTAIN_TICKS > 1) ? $clog2(SUSTAIN_TICKS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(ENV_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SUSTAIN_TICKS - 1);
    localparam logic [7:0]         ATK_STEP8  = 8'(ATTACK_STEP);
    localparam logic [7:0]         DEC_STEP8  = 8'(DECAY_STEP);

    env_state_t         state_q, state_d;
    logic [7:0]         level_q, level_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]   duty_pending_q, duty_pending_d;
    logic               env_tick;
    logic [7:0]         level_step;

    // Envelope FSM and prescaler.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        hold_d     = hold_q;
        presc_d    = presc_q;
        level_step = level_q;

        env_tick = (state_q != IDLE) && (presc_q == PRESC_LAST);

        if (state_q != IDLE) begin
            presc_d = env_tick ? '0 : presc_q + PRESC_W'(1);
        end

        if (note_start_i) begin
            // Retrigger keeps the current level so the restart is click-free.
            state_d = ATTACK;
            presc_d = '0;
            hold_d  = '0;
        end else if (env_tick) begin
            unique case (state_q)
                ATTACK: begin
                    level_step = sat_add(level_q, ATK_STEP8);
                    level_d    = level_step;
                    if (level_step == LEVEL_MAX) begin
                        state_d = SUSTAIN;
                        hold_d  = '0;
                    end
                end
                SUSTAIN: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = DECAY;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                DECAY: begin
                    level_step = sat_sub(level_q, DEC_STEP8);
                    level_d    = level_step;
                    if (level_step == 8'd0) begin
                        state_d = IDLE;
                    end
                end
                IDLE: ;
                default: ;
            endcase
        end
    end

    // Sample scaling: top byte of sample*level, using the level before any
    // same-cycle envelope update.
    always_comb begin
        duty_pending_d = duty_pending_q;
        if (sample_tick_i) begin
            duty_pending_d = 8'(({8'd0, sample_i} * {8'd0, level_q}) >> 8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            level_q        <= '0;
            hold_q         <= '0;
            presc_q        <= '0;
            duty_pending_q <= '0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            hold_q         <= hold_d;
            presc_q        <= presc_d;
            duty_pending_q <= duty_pending_d;
        end
    end

    pwm_modulator u_pwm (
        .clk            (clk),
        .rst            (rst),
        .duty_pending_i (duty_pending_q),
        .pwm_o          (pwm_o)
    );

    assign level_o = level_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_sound_envelope_pwm.sv
module tb_sound_envelope_pwm;

    localparam int unsigned ENV_DIV       = 4;
    localparam int unsigned ATTACK_STEP   = 64;
    localparam int unsigned DECAY_STEP    = 32;
    localparam int unsigned SUSTAIN_TICKS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sample_i = 8'd0;
    logic       sample_tick_i = 1'b0;
    logic       note_start_i = 1'b0;
    logic       pwm_o;
    logic [7:0] level_o;
    logic       busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural reference: phase 0 idle, 1 attack, 2 sustain, 3 decay.
    int m_st, m_lvl, m_since, m_hold, m_dp, m_duty, m_pwm, m_c;

    always #5 clk = ~clk;

    sound_envelope_pwm #(
        .ENV_DIV       (ENV_DIV),
        .ATTACK_STEP   (ATTACK_STEP),
        .DECAY_STEP    (DECAY_STEP),
        .SUSTAIN_TICKS (SUSTAIN_TICKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_i      (sample_i),
        .sample_tick_i (sample_tick_i),
        .note_start_i  (note_start_i),
        .pwm_o         (pwm_o),
        .level_o       (level_o),
        .busy_o        (busy_o)
    );

    // Advance the reference by one clock using the inputs seen at that edge.
    // m_since counts cycles since the last note start; m_c counts cycles since reset.
    task automatic model_step();
        int tick, old_dp;
        if (rst) begin
            m_st = 0; m_lvl = 0; m_since = 0; m_hold = 0;
            m_dp = 0; m_duty = 0; m_pwm = 0; m_c = 0;
        end else begin
            tick = (m_st != 0 && (m_since % ENV_DIV) == ENV_DIV - 1) ? 1 : 0;
            old_dp = m_dp;
            if (sample_tick_i) m_dp = (int'(sample_i) * m_lvl) / 256;
            if ((m_c % 256) == 255) m_duty = old_dp;
            m_c = m_c + 1;
            m_pwm = ((m_c % 256) < m_duty) ? 1 : 0;
            if (note_start_i) begin
                m_st = 1; m_since = 0; m_hold = 0;
            end else begin
                m_since = m_since + 1;
                if (tick != 0) begin
                    case (m_st)
                        1: begin
                            m_lvl = (m_lvl + ATTACK_STEP > 255) ? 255 : m_lvl + ATTACK_STEP;
                            if (m_lvl == 255) begin m_st = 2; m_hold = 0; end
                        end
                        2: begin
                            m_hold = m_hold + 1;
                            if (m_hold == SUSTAIN_TICKS) m_st = 3;
                        end
                        3: begin
                            m_lvl = (m_lvl < DECAY_STEP) ? 0 : m_lvl - DECAY_STEP;
                            if (m_lvl == 0) m_st = 0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (level_o !== 8'd0 || busy_o !== 1'b0 || pwm_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: level=%0d busy=%b pwm=%b, want 0/0/0",
                         level_o, busy_o, pwm_o);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            sample_i = 8'($urandom);
            sample_tick_i = $urandom_range(0, 1) == 1;
            cyc();
            n_cmp++;
            if (level_o !== 8'd0 || busy_o !== 1'b0 || pwm_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_note: level=%0d busy=%b pwm=%b, want 0/0/0",
                         level_o, busy_o, pwm_o);
            end
        end
        sample_tick_i = 1'b0;
    endtask

    task automatic test_attack();
        int lv[$];
        int gaps[$];
        int exp_lv[4] = '{64, 128, 192, 255};
        int prev, last;
        bit done;
        note_start_i = 1'b1;
        cyc();
        note_start_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL attack_busy_rise: busy=%b, want 1", busy_o);
        end
        prev = int'(level_o); last = 0; done = 0;
        for (int i = 1; i <= 40 && !done; i++) begin
            cyc();
            n_cmp++;
            if (level_o !== 8'(m_lvl) || busy_o !== (m_st != 0)) begin
                n_fail++;
                $display("FAIL attack_model: level=%0d busy=%b, want %0d/%0d",
                         level_o, busy_o, m_lvl, m_st != 0);
            end
            if (int'(level_o) != prev) begin
                lv.push_back(int'(level_o));
                gaps.push_back(i - last);
                last = i;
                prev = int'(level_o);
                if (level_o == 8'd255) done = 1;
            end
        end
        n_cmp++;
        if (!done || lv.size() != 4) begin
            n_fail++;
            $display("FAIL attack_steps: reached_max=%0d steps=%0d, want 1/4", done, lv.size());
        end
        for (int k = 0; k < 4 && k < lv.size(); k++) begin
            n_cmp++;
            if (lv[k] != exp_lv[k] || gaps[k] != 4) begin
                n_fail++;
                $display("FAIL attack_step%0d: level=%0d gap=%0d, want %0d/4",
                         k, lv[k], gaps[k], exp_lv[k]);
            end
        end
    endtask

    task automatic test_full_envelope();
        int lv[$];
        int gaps[$];
        int exp_lv[8] = '{223, 191, 159, 127, 95, 63, 31, 0};
        int prev, last;
        bit done;
        prev = int'(level_o); last = 0; done = 0;
        for (int i = 1; i <= 120 && !done; i++) begin
            cyc();
            n_cmp++;
            if (level_o !== 8'(m_lvl) || busy_o !== (m_st != 0) || pwm_o !== (m_pwm != 0)) begin
                n_fail++;
                $display("FAIL envelope_model: level=%0d busy=%b pwm=%b, want %0d/%0d/%0d",
                         level_o, busy_o, pwm_o, m_lvl, m_st != 0, m_pwm);
            end
            if (int'(level_o) != prev) begin
                lv.push_back(int'(level_o));
                gaps.push_back(i - last);
                last = i;
                prev = int'(level_o);
                n_cmp++;
                if (busy_o !== (level_o != 8'd0)) begin
                    n_fail++;
                    $display("FAIL envelope_busy: level=%0d busy=%b, want busy=%0d",
                             level_o, busy_o, level_o != 8'd0);
                end
                if (level_o == 8'd0) done = 1;
            end
        end
        n_cmp++;
        if (!done || lv.size() != 8) begin
            n_fail++;
            $display("FAIL envelope_steps: ended=%0d steps=%0d, want 1/8", done, lv.size());
        end
        for (int k = 0; k < 8 && k < lv.size(); k++) begin
            n_cmp++;
            // Two sustain ticks plus the first decay tick before the first drop.
            if (lv[k] != exp_lv[k] || gaps[k] != ((k == 0) ? 12 : 4)) begin
                n_fail++;
                $display("FAIL decay_step%0d: level=%0d gap=%0d, want %0d/%0d",
                         k, lv[k], gaps[k], exp_lv[k], (k == 0) ? 12 : 4);
            end
        end
    endtask

    task automatic test_pwm_scaling();
        int highs;
        bit found;
        note_start_i = 1'b1;
        cyc();
        note_start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (level_o == 8'd255) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL pwm_reach_max: level=%0d, want 255", level_o);
        end
        sample_i = 8'd200;
        sample_tick_i = 1'b1;
        cyc();
        sample_tick_i = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc();
            if ((m_c % 256) == 0) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL pwm_boundary: no period boundary seen, want one within 300 cycles");
        end
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) cyc();
            highs += (pwm_o === 1'b1) ? 1 : 0;
            n_cmp++;
            if (pwm_o !== (m_pwm != 0)) begin
                n_fail++;
                $display("FAIL pwm_model: pwm=%b, want %0d (cnt %0d)", pwm_o, m_pwm, m_c % 256);
            end
        end
        n_cmp++;
        if (highs != 199) begin
            n_fail++;
            $display("FAIL pwm_duty_199: high=%0d of 256, want 199", highs);
        end
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (busy_o == 1'b0) found = 1;
        end
        n_cmp++;
        if (!found || level_o !== 8'd0) begin
            n_fail++;
            $display("FAIL pwm_note_end: busy=%b level=%0d, want 0/0", busy_o, level_o);
        end
    endtask

    task automatic test_retrigger();
        int lv[$];
        int prev;
        bit found;
        note_start_i = 1'b1;
        cyc();
        note_start_i = 1'b0;
        found = 0;
        for (int i = 0; i < 120 && !found; i++) begin
            cyc();
            if (level_o == 8'd127 && m_st == 3) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL retrig_reach127: level=%0d, want 127 in decay", level_o);
        end
        note_start_i = 1'b1;
        cyc();
        note_start_i = 1'b0;
        prev = int'(level_o);
        for (int i = 0; i < 40 && lv.size() < 2; i++) begin
            cyc();
            n_cmp++;
            if (level_o === 8'd0 || busy_o !== 1'b1 || level_o !== 8'(m_lvl)) begin
                n_fail++;
                $display("FAIL retrig_hold: level=%0d busy=%b, want %0d/1",
                         level_o, busy_o, m_lvl);
            end
            if (int'(level_o) != prev) begin
                lv.push_back(int'(level_o));
                prev = int'(level_o);
            end
        end
        n_cmp++;
        if (lv.size() != 2) begin
            n_fail++;
            $display("FAIL retrig_steps: steps=%0d, want 2", lv.size());
        end else begin
            n_cmp++;
            if (lv[0] != 191 || lv[1] != 255) begin
                n_fail++;
                $display("FAIL retrig_levels: got %0d,%0d, want 191,255", lv[0], lv[1]);
            end
        end
    endtask

    task automatic test_reset_mid_note();
        cyc();
        n_cmp++;
        if (busy_o !== 1'b1 || m_st != 2) begin
            n_fail++;
            $display("FAIL midrst_pre: busy=%b phase=%0d, want 1/sustain", busy_o, m_st);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (level_o !== 8'd0 || busy_o !== 1'b0 || pwm_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: level=%0d busy=%b pwm=%b, want 0/0/0", level_o, busy_o, pwm_o);
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_cmp++;
            if (level_o !== 8'd0 || busy_o !== 1'b0 || pwm_o !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_after: level=%0d busy=%b pwm=%b, want 0/0/0",
                         level_o, busy_o, pwm_o);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            note_start_i  = $urandom_range(0, 59) == 0;
            sample_tick_i = $urandom_range(0, 3) == 0;
            sample_i      = 8'($urandom);
            rst           = $urandom_range(0, 1999) == 0;
            cyc();
            n_cmp++;
            if (level_o !== 8'(m_lvl) || busy_o !== (m_st != 0) || pwm_o !== (m_pwm != 0)) begin
                n_fail++;
                $display("FAIL random_c%0d: level=%0d busy=%b pwm=%b, want %0d/%0d/%0d",
                         i, level_o, busy_o, pwm_o, m_lvl, m_st != 0, m_pwm);
            end
        end
        note_start_i = 1'b0;
        sample_tick_i = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_attack();
        test_full_envelope();
        test_pwm_scaling();
        test_retrigger();
        test_reset_mid_note();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
